// File: rtl/brc_seq_if.sv
// Request/response bundle for the sequential branch comparator (brc_seq).
// The slave modport is the comparator side; the master modport is the requester/consumer side.
interface brc_seq_if #(
  parameter int WIDTH = 32
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
  // A raised valid holds steady, with its payload, until that edge.
  // Request: i_valid/o_ready carry i_rs1_data, i_rs2_data and i_br_unsigned.
  // Response: o_valid/i_ready carry o_br_less and o_br_equal.
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_rs1_data;
  logic [WIDTH-1:0] i_rs2_data;
  logic             i_br_unsigned;
  logic             o_valid;
  logic             i_ready;
  logic             o_br_less;
  logic             o_br_equal;

  modport slave (
    input  i_valid, i_rs1_data, i_rs2_data, i_br_unsigned, i_ready,
    output o_ready, o_valid, o_br_less, o_br_equal
  );

  modport master (
    output i_valid, i_rs1_data, i_rs2_data, i_br_unsigned, i_ready,
    input  o_ready, o_valid, o_br_less, o_br_equal
  );
endinterface

// File: rtl/brc_seq.sv
// Sequential less/equal comparator. It examines one CHUNK-bit slice per cycle, MSB slice first.
// Define BRC_SEQ_EARLY_EXIT_EN to finish on the first differing slice; without it, every request takes NCHUNK cycles.
module brc_seq #(
  parameter int WIDTH = 32,  // >= 2
  parameter int CHUNK = 8    // >= 1, must divide WIDTH
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  brc_seq_if.slave    bus,
  output logic [1:0]  dbg_state
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  TOP_IDX  = IDXW'(NCHUNK - 1);
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              uns_q;
  logic [IDXW-1:0]   idx_q;
  logic              found_q, less_q, equal_q;

  logic [CHUNK-1:0]  a_sl, b_sl, flip;
  logic              diff, slice_lt, last;

  // Flipping the slice MSB maps a signed compare onto an unsigned one; only the top slice carries the sign.
  always_comb begin
    a_sl     = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_sl     = b_q[int'(idx_q)*CHUNK +: CHUNK];
    flip     = (idx_q == TOP_IDX && !uns_q) ? MSB_MASK : '0;
    diff     = (a_sl != b_sl);
    slice_lt = ((a_sl ^ flip) < (b_sl ^ flip));
    last     = (idx_q == '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.i_valid) state_nx = CMP;
      CMP: begin
`ifdef BRC_SEQ_EARLY_EXIT_EN
        if (last || diff) state_nx = DONE;
`else
        if (last) state_nx = DONE;
`endif
      end
      DONE: if (bus.i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      uns_q   <= 1'b0;
      idx_q   <= '0;
      found_q <= 1'b0;
      less_q  <= 1'b0;
      equal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            a_q     <= bus.i_rs1_data;
            b_q     <= bus.i_rs2_data;
            uns_q   <= bus.i_br_unsigned;
            idx_q   <= TOP_IDX;
            found_q <= 1'b0;
            less_q  <= 1'b0;
            equal_q <= 1'b0;
          end
        end
        CMP: begin
          // The first differing slice decides; lower slices keep scanning only to hold constant latency.
          if (diff && !found_q) begin
            found_q <= 1'b1;
            less_q  <= slice_lt;
          end
          if (!last) idx_q <= idx_q - 1'b1;
          if (state_nx == DONE) equal_q <= !(found_q || diff);
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready    = (state == IDLE);
  assign bus.o_valid    = (state == DONE);
  assign bus.o_br_less  = (state == DONE) && less_q;
  assign bus.o_br_equal = (state == DONE) && equal_q;
  assign dbg_state      = state;
endmodule

// File: tb/tb_brc_seq.sv
// Directed bench for brc_seq: WIDTH=32/CHUNK=8, WIDTH=8/CHUNK=1 and WIDTH=16/CHUNK=16 instances.
// Expected latencies follow BRC_SEQ_EARLY_EXIT_EN when the bench is built with it.
module tb_brc_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef BRC_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  brc_seq_if #(.WIDTH(32)) b32();
  brc_seq_if #(.WIDTH(8))  b8();
  brc_seq_if #(.WIDTH(16)) b16();
  logic [1:0] st32, st8, st16;

  brc_seq #(.WIDTH(32), .CHUNK(8))  dut32 (.i_clk(clk), .i_rst_n(rst_n), .bus(b32), .dbg_state(st32));
  brc_seq #(.WIDTH(8),  .CHUNK(1))  dut8  (.i_clk(clk), .i_rst_n(rst_n), .bus(b8),  .dbg_state(st8));
  brc_seq #(.WIDTH(16), .CHUNK(16)) dut16 (.i_clk(clk), .i_rst_n(rst_n), .bus(b16), .dbg_state(st16));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {o_ready, o_valid, o_br_less, o_br_equal}
  function automatic logic [3:0] obs(input int sel);
    case (sel)
      0:       return {b32.o_ready, b32.o_valid, b32.o_br_less, b32.o_br_equal};
      1:       return {b8.o_ready,  b8.o_valid,  b8.o_br_less,  b8.o_br_equal};
      default: return {b16.o_ready, b16.o_valid, b16.o_br_less, b16.o_br_equal};
    endcase
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic u, input logic r);
    case (sel)
      0: begin
        b32.i_valid = v; b32.i_rs1_data = a; b32.i_rs2_data = b;
        b32.i_br_unsigned = u; b32.i_ready = r;
      end
      1: begin
        b8.i_valid = v; b8.i_rs1_data = a[7:0]; b8.i_rs2_data = b[7:0];
        b8.i_br_unsigned = u; b8.i_ready = r;
      end
      default: begin
        b16.i_valid = v; b16.i_rs1_data = a[15:0]; b16.i_rs2_data = b[15:0];
        b16.i_br_unsigned = u; b16.i_ready = r;
      end
    endcase
  endtask

  // Number of slices examined before the result, counting from the MSB slice.
  function automatic int first_k(input logic [31:0] a, input logic [31:0] b, input int w, input int c);
    int n;
    logic [31:0] mask;
    n = w / c;
    mask = (c == 32) ? 32'hFFFF_FFFF : ((32'd1 << c) - 32'd1);
    for (int i = n - 1; i >= 0; i--)
      if ((((a >> (i * c)) ^ (b >> (i * c))) & mask) != 32'd0) return n - i;
    return n;
  endfunction

  function automatic int lat_exp(input int k, input int n);
    return EARLY ? k : n;
  endfunction

  task automatic run(input int sel, input logic [31:0] a, input logic [31:0] b, input logic u,
                     input logic el, input logic ee, input int elat, input int hold, input string tag);
    int lat;
    logic [3:0] o;
    drive(sel, 1'b1, a, b, u, 1'b0);
    @(posedge clk); #1;
    drive(sel, 1'b0, ~a, ~b, ~u, 1'b0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      o = obs(sel);
    end while (o[2] == 1'b0 && lat < 64);
    check({tag, " latency"}, lat, elat);
    check({tag, " result"}, o, {2'b01, el, ee});
    if (sel == 0) check({tag, " state"}, st32, 2'd2);
    for (int i = 0; i < hold; i++) begin
      drive(sel, 1'b1, $urandom, $urandom, 1'(i), 1'b0);
      @(posedge clk); #1;
      check({tag, " hold"}, obs(sel), {2'b01, el, ee});
    end
    drive(sel, 1'b0, a, b, u, 1'b1);
    @(posedge clk); #1;
    drive(sel, 1'b0, a, b, u, 1'b0);
    check({tag, " return"}, obs(sel), 4'b1000);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [7:0]  a8, b8v;
    logic [15:0] a16, b16v;
    logic        u, el;

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset 32", obs(0), 4'b1000);
    check("reset 8", obs(1), 4'b1000);
    check("reset 16", obs(2), 4'b1000);
    check("reset state", st32, 2'd0);
    rst_n = 1'b1;

    run(0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, lat_exp(1, 4), 0, "uns 1<ffffffff");
    run(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, lat_exp(1, 4), 0, "sgn -1<1");
    run(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, lat_exp(1, 4), 0, "uns ffffffff>1");
    run(0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 4, 0, "sgn equal");
    run(0, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 4, 0, "uns equal");
    run(0, 32'h1234_5600, 32'h1234_5601, 1'b1, 1'b1, 1'b0, 4, 0, "uns low slice");
    run(0, 32'hFFFF_FF80, 32'hFFFF_FF7F, 1'b0, 1'b0, 1'b0, 4, 0, "sgn low unsigned");
    run(0, 32'h7F00_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, lat_exp(1, 4), 0, "sgn max>min");
    run(0, 32'h0012_0000, 32'h0034_0000, 1'b0, 1'b1, 1'b0, lat_exp(2, 4), 0, "sgn 2nd slice");
    run(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, lat_exp(1, 4), 5, "backpressure");

    // Reset lands on the edge closing the second CMP cycle.
    drive(0, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid reset outputs", obs(0), 4'b1000);
    check("mid reset state", st32, 2'd0);
    run(0, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, lat_exp(1, 4), 0, "after reset");

    run(1, 32'h80, 32'h7F, 1'b0, 1'b1, 1'b0, lat_exp(1, 8), 0, "w8 sgn 80<7f");
    run(1, 32'h80, 32'h7F, 1'b1, 1'b0, 1'b0, lat_exp(1, 8), 0, "w8 uns 80>7f");
    run(2, 32'hFFFE, 32'hFFFF, 1'b0, 1'b1, 1'b0, 1, 0, "w16 sgn -2<-1");
    run(2, 32'h8000, 32'h0001, 1'b1, 1'b0, 1'b0, 1, 0, "w16 uns 8000>1");

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i < 2) ? a : $urandom;
      u = 1'($urandom_range(0, 1));
      a8 = a[7:0];
      b8v = b[7:0];
      el = u ? (a8 < b8v) : ($signed(a8) < $signed(b8v));
      run(1, a, b, u, el, a8 == b8v, lat_exp(first_k(a, b, 8, 1), 8), 0, "w8 random");
      a16 = a[15:0];
      b16v = b[15:0];
      el = u ? (a16 < b16v) : ($signed(a16) < $signed(b16v));
      run(2, a, b, u, el, a16 == b16v, 1, 0, "w16 random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/brc_seq.md
BRC_SEQ -- requirements
Module: brc_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 8, bits compared per cycle; SHALL be >= 1 and divide WIDTH exactly; NCHUNK = WIDTH/CHUNK.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_valid  input  1  request valid.
REQ-006 o_ready  output  1  block can accept a request.
REQ-007 i_rs1_data  input  WIDTH  operand A.
REQ-008 i_rs2_data  input  WIDTH  operand B.
REQ-009 i_br_unsigned  input  1  1 = unsigned compare, 0 = two's-complement signed compare.
REQ-010 o_valid  output  1  result valid.
REQ-011 i_ready  input  1  consumer accepts result.
REQ-012 o_br_less  output  1  A < B under the captured mode.
REQ-013 o_br_equal  output  1  A == B.

Function
REQ-014 The FSM SHALL have three states: IDLE, CMP and DONE.
REQ-015 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE.
REQ-016 Acceptance: IDLE with i_valid=1 SHALL register A, B and i_br_unsigned, set chunk index to NCHUNK-1 and enter CMP.
REQ-017 Operands and mode SHALL be sampled only at acceptance; later input changes SHALL have no effect.
REQ-018 Each CMP cycle SHALL compare exactly one CHUNK-bit slice, MSB slice first, then decrement the index.
REQ-019 Top slice in signed mode SHALL be compared as signed; all other slices, and every slice in unsigned mode, SHALL be compared as unsigned.
REQ-020 The first differing slice SHALL fix the results: less = (A slice < B slice), equal = 0; later slices SHALL NOT alter them.
REQ-021 If all NCHUNK slices are equal, the results SHALL be less = 0, equal = 1.
REQ-022 CMP SHALL go to DONE after the last slice (index 0), or earlier as defined in REQ-030.
REQ-023 DONE SHALL hold o_br_less and o_br_equal stable until i_ready=1, then return to IDLE on that edge.
REQ-024 o_valid SHALL NOT drop without an i_ready handshake; any backpressure duration SHALL be tolerated.
REQ-025 If acceptance is at edge E0 and k slices are examined, o_valid SHALL rise at edge E0+k; the maximum is NCHUNK.
REQ-026 For WIDTH == CHUNK, exactly one CMP cycle SHALL occur.
REQ-027 Outside DONE, o_br_less and o_br_equal SHALL be 0.

Reset
REQ-028 While i_rst_n=0 at a clock edge, the state SHALL become IDLE and the registered operands, mode, index and results SHALL clear to 0.
REQ-029 Reset in CMP or DONE SHALL discard the operation; the first cycle after release SHALL show o_ready=1, o_valid=0, o_br_less=0 and o_br_equal=0.

Configuration
REQ-030 With macro BRC_SEQ_EARLY_EXIT_EN defined, CMP SHALL enter DONE on the cycle the first differing slice is found.
REQ-031 Without BRC_SEQ_EARLY_EXIT_EN, CMP SHALL always run NCHUNK cycles (constant time); results SHALL be identical to those in REQ-030.

Verification
REQ-032 Unsigned mode, WIDTH=32, CHUNK=8, A=0x0000_0001, B=0xFFFF_FFFF -> less=1, equal=0; o_valid at E0+1 with the early-exit macro, at E0+4 without it.
REQ-033 Signed mode, A=0xFFFF_FFFF (-1), B=0x0000_0001 -> less=1, equal=0; unsigned mode, same operands -> less=0, equal=0.
REQ-034 A=B=0x1234_5678, both modes -> less=0, equal=1, o_valid at E0+4 in both builds.
REQ-035 Result ready with i_ready held low for 5 cycles, while inputs change and i_valid=1 -> outputs stable, o_ready=0, no new acceptance; on i_ready=1, return to IDLE.
REQ-036 Reset pulsed in the 2nd CMP cycle of A=0x8000_0000, B=0x0000_0000 -> next cycle o_ready=1, o_valid=0; a fresh signed request yields less=1.
REQ-037 Configurations WIDTH=8/CHUNK=1 and WIDTH=16/CHUNK=16 with random signed and unsigned operands -> results match the reference compare.
